pwm_ramp_ctrl: RTL

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_ramp_ctrl_pkg.sv | 29 ++
 rtl/ramp_step_timer.sv | 43 ++++
 rtl/pwm_ramp_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pwm_ramp_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pwm_ramp_ctrl_pkg
//
// Shared definitions for the PWM duty ramp controller and the PWM stage it
// drives. The PWM stage imports this package so both sides agree on the
// duty-code width and can decode the controller state.
//
// Contents:
//   DUTY_W_DEF    default width of the duty code (matches the PWM duty input)
//   STEP_W_DEF    default width of the step-interval field
//   ramp_state_e  ramp controller FSM states
// -----------------------------------------------------------------------------
package pwm_ramp_ctrl_pkg;

  localparam int DUTY_W_DEF = 3;
  localparam int STEP_W_DEF = 8;

  // IDLE      : output disabled, duty forced to zero
  // RAMP_UP   : stepping duty one code at a time toward target
  // RUN       : duty parked at target
  // RAMP_DOWN : stepping duty toward zero before disabling the output
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } ramp_state_e;

endpackage : pwm_ramp_ctrl_pkg

// File: rtl/ramp_step_timer.sv
// -----------------------------------------------------------------------------
// ramp_step_timer
//
// Down-counter that paces duty changes in the ramp controller. A load copies
// div into the counter; otherwise the counter decrements toward zero and then
// rests there. step is high whenever the counter is zero, so reloading on
// every step gives exactly div+1 cycles between steps, and div=0 steps every
// cycle.
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset, clears the counter to zero
//   load  in   reload the counter from div this cycle
//   div   in   STEP_W  interval minus one, sampled only when load is high
//   step  out  high while the counter is zero
// -----------------------------------------------------------------------------
module ramp_step_timer #(
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [STEP_W-1:0] div,
  output logic              step
);

  logic [STEP_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= div;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // The counter parks at zero, so step stays high outside the ramp states.
  // The controller only acts on it while ramping, so this is harmless.
  assign step = (cnt == '0);

endmodule : ramp_step_timer

// File: rtl/pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_ramp_ctrl
//
// Soft-start / soft-stop controller for a PWM stage. On start it walks the
// duty code one step at a time toward target, parks there, follows later
// target changes with the same ramp, and on stop walks the duty back to zero,
// holds zero for one step interval and then drops the enable.
//
// Control inputs are single-cycle request pulses with no handshake: start and
// stop are acted on in the cycle they are high and there is no ready/ack
// path. When both are high in the same cycle, stop wins in every state.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset, overrides all inputs
//   start      in   request to begin or resume ramping toward target
//   stop       in   request to ramp down to zero and disable
//   target     in   DUTY_W  requested steady-state duty, sampled every cycle
//   step_div   in   STEP_W  step interval minus one, sampled at timer reload
//   duty       out  DUTY_W  registered duty code for the PWM stage
//   pwm_en     out  registered enable for the PWM stage
//   busy       out  registered, high in any state other than IDLE
//   at_target  out  registered, high in RUN only
//   done       out  registered one-cycle pulse on RAMP_DOWN -> IDLE
//   dbg_state  out  current FSM state, for observation only
// -----------------------------------------------------------------------------
module pwm_ramp_ctrl
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF,
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [DUTY_W-1:0] target,
  input  logic [STEP_W-1:0] step_div,
  output logic [DUTY_W-1:0] duty,
  output logic              pwm_en,
  output logic              busy,
  output logic              at_target,
  output logic              done,
  output ramp_state_e       dbg_state
);

  ramp_state_e       state;
  ramp_state_e       state_n;
  logic [DUTY_W-1:0] duty_n;
  logic [DUTY_W-1:0] duty_toward;
  logic              done_n;
  logic              load;
  logic              step;
  logic              go;

  // A start that coincides with a stop is discarded so stop always wins.
  assign go = start & ~stop;

  // One code toward target. Only consumed while duty != target, so neither
  // branch can wrap: an increment implies duty < target <= max code, and a
  // decrement implies duty > target >= 0.
  assign duty_toward = (target > duty) ? duty + 1'b1 : duty - 1'b1;

  ramp_step_timer #(
    .STEP_W (STEP_W)
  ) u_step_timer (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .div  (step_div),
    .step (step)
  );

  // ---------------------------------------------------------------------------
  // Next-state, next-duty and timer-load decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    duty_n  = duty;
    done_n  = 1'b0;
    load    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // stop has nothing to undo here and is dropped.
        if (go) begin
          state_n = ST_RAMP_UP;
          load    = 1'b1;
        end
      end

      ST_RAMP_UP: begin
        if (stop) begin
          state_n = ST_RAMP_DOWN;
          load    = 1'b1;
        end else if (duty == target) begin
          // Covers arriving with duty already on target (e.g. target=0 from
          // IDLE) and a target that moved onto the current duty mid-interval.
          state_n = ST_RUN;
        end else if (step) begin
          duty_n = duty_toward;
          load   = 1'b1;
          // Enter RUN on the same edge as the final step so at_target rises
          // together with the duty reaching target.
          if (duty_toward == target) begin
            state_n = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_n = ST_RAMP_DOWN;
          load    = 1'b1;
        end else if (target != duty) begin
          // Re-ramp toward the new target; a full interval passes before
          // the first duty change.
          state_n = ST_RAMP_UP;
          load    = 1'b1;
        end
      end

      ST_RAMP_DOWN: begin
        if (go) begin
          // Resume from the current duty rather than restarting from zero.
          state_n = ST_RAMP_UP;
          load    = 1'b1;
        end else if (step) begin
          if (duty == '0) begin
            // Zero has been on the output for a whole interval: disable.
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            duty_n = duty - 1'b1;
            load   = 1'b1;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
        duty_n  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers. Outputs are derived from the next state so a
  // request sampled on one edge is visible on the outputs right after it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      duty      <= '0;
      pwm_en    <= 1'b0;
      busy      <= 1'b0;
      at_target <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      duty      <= duty_n;
      pwm_en    <= (state_n != ST_IDLE);
      busy      <= (state_n != ST_IDLE);
      at_target <= (state_n == ST_RUN);
      done      <= done_n;
    end
  end

  assign dbg_state = state;

endmodule : pwm_ramp_ctrl
